dmem_boot_loader: RTL
=====================

// Module: dmem_boot_loader
// PURPOSE
//  Byte-stream loader upstream of dmem: receives word count + payload bytes, writes words into dmem.
//  Holds the processor in reset until the load completes.
//  Owns the dmem port while loading; passes processor dmem signals through once done.
//  Sits between processor/dmem at top level; clocked by the processor-side clock.
// PARAMETERS
//  ADDR_W     12   dmem address width
//  DATA_W     32   dmem word width (multiple of 8)
//  BASE_ADDR  0    first dmem word address written
//  MAX_WORDS  4096 largest accepted word count; larger -> ERROR
// PORTS
//  clock           in   1       master clock, rising edge
//  reset           in   1       asynchronous, active-low
//  rx_valid        in   1       byte available on rx_byte
//  rx_byte         in   8       incoming byte
//  rx_ready        out  1       loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//  cpu_address     in   ADDR_W  processor dmem address
//  cpu_data        in   DATA_W  processor dmem write data
//  cpu_wren        in   1       processor dmem write enable
//  address_dmem    out  ADDR_W  to dmem address
//  data            out  DATA_W  to dmem write data
//  wren            out  1       to dmem write enable
//  cpu_reset       out  1       active-high reset to processor; high until DONE
//  done            out  1       load finished successfully
//  error           out  1       load aborted
//  words_loaded    out  ADDR_W+1  words written so far
// BEHAVIOUR
//  Reset (async assert, sync release): state=LEN_HI, rx_ready=0 for 1 cycle then 1, wren=0.
//   cpu_reset=1, done=0, error=0, words_loaded=0, address_dmem=BASE_ADDR, data=0.
//  Reset mid-load discards partial word/count; dmem contents are not cleared.
//  States: LEN_HI -> LEN_LO -> DATA -> WRITE -> (CHK) -> DONE | ERROR.
//  LEN_HI/LEN_LO: 16-bit word count N, big-endian, one byte per transfer.
//   After LEN_LO: N==0 -> DONE (or CHK); N>MAX_WORDS -> ERROR; else DATA.
//  DATA: packs 4 bytes big-endian (first byte -> bits 31:24); 4th transfer -> WRITE.
//  WRITE: exactly one cycle, rx_ready=0, wren=1.
//   address_dmem = BASE_ADDR+words_loaded, truncated mod 2^ADDR_W (wraps).
//   words_loaded increments; ==N -> DONE (or CHK); else DATA.
//  Latency: wren high the cycle after the 4th byte is accepted; max throughput 1 word / 5 cycles.
//  rx_valid low stalls any state with no side effect; rx_byte is ignored when rx_valid=0.
//  DONE: rx_ready=0; cpu_reset drops the cycle after DONE entry; done=1; sticky until reset.
//   Mux switches to cpu_* signals the same cycle cpu_reset drops.
//  ERROR: rx_ready=0; error=1; cpu_reset stays 1; wren=0; sticky until reset.
//  In every state except DONE the cpu_* inputs are ignored (cpu_wren can never reach dmem).
// CONFIGURATION
//  DMEM_BOOT_CHECKSUM_EN defined:
//   - Running XOR of all length and payload bytes.
//   - After the last word, CHK state accepts one byte; equal -> DONE, differ -> ERROR.
//   - Words already written stay in dmem after an ERROR.
//  Not defined: no CHK state; DONE follows the last WRITE directly (or LEN_LO when N==0).
// STRUCTURE
//  Package boot_pkg:
//   - state enum
//   - LEN_BYTES=2 and BYTES_PER_WORD=DATA_W/8
//   - CHK_INIT=8'h00
//  Sub-module byte_to_word_packer: shift register + byte index; load/clear inputs; word_valid pulse.
//  Top-level FSM, counters and the dmem output mux live in dmem_boot_loader.
// TESTING
//  - N=2, bytes DE AD BE EF 01 02 03 04: wren pulses write 0xDEADBEEF @0, 0x01020304 @1.
//    done=1; cpu_reset falls one cycle after the second write.
//  - N=0: DONE with no wren pulse; cpu_* pass through afterwards.
//  - N=4097 (MAX_WORDS=4096): ERROR after LEN_LO; cpu_reset stays 1; cpu_wren=1 never reaches wren.
//  - rx_valid gaps of 0-7 random cycles in the first scenario: identical dmem writes, order and values.
//  - reset low after 2 payload bytes, then a fresh N=1 stream 11223344: single write 0x11223344 @BASE_ADDR.
//  - DMEM_BOOT_CHECKSUM_EN, N=1, AA BB CC DD:
//    - checksum 0x01^0xAA^0xBB^0xCC^0xDD -> DONE.
//    - Any other checksum byte -> error=1, cpu_reset=1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the dmem boot loader.
// Optional checksum stage is enabled by defining DMEM_BOOT_CHECKSUM_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StChk,
        StDone,
        StError
    } boot_state_e;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned DMEM_DATA_W    = 32;
    localparam int unsigned BYTES_PER_WORD = DMEM_DATA_W / 8;
    localparam logic [7:0]  CHK_INIT       = 8'h00;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Packs a byte stream into big-endian words; word_valid_o pulses on the byte that completes a word.
module byte_to_word_packer
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int unsigned Bpw  = bytes_per_word(DATA_W);
    localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Bpw - 1);

    logic [DATA_W-1:0] word_q, word_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    always_comb begin
        word_d       = word_q;
        idx_d        = idx_q;
        word_valid_o = 1'b0;
        if (clear_i) begin
            idx_d = '0;
        end else if (load_i) begin
            // First byte of a word ends up in the most significant lane.
            word_d       = (word_q << 8) | DATA_W'(byte_i);
            word_valid_o = (idx_q == LastIdx);
            idx_d        = word_valid_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/dmem_boot_loader.sv
// Byte-stream boot loader: writes a length-prefixed payload into dmem, then hands dmem to the CPU.
// Define DMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module dmem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 8 * BYTES_PER_WORD,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_wren,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned LenW = 8 * LEN_BYTES;
    localparam int unsigned CntW = ADDR_W + 1;

`ifdef DMEM_BOOT_CHECKSUM_EN
    localparam boot_state_e StFinal = StChk;
`else
    localparam boot_state_e StFinal = StDone;
`endif

    boot_state_e       state_q, state_d;
    logic              armed_q;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [CntW-1:0]   words_q, words_d;
    logic [LenW-1:0]   len_rx;
    logic [CntW-1:0]   words_inc;
    logic              rx_fire;
    logic              pk_clear, pk_load, pk_valid;
    logic [DATA_W-1:0] pk_word;
`ifdef DMEM_BOOT_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    byte_to_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk_i        (clock),
        .rst_n        (reset),
        .clear_i      (pk_clear),
        .load_i       (pk_load),
        .byte_i       (rx_byte),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    // armed_q keeps rx_ready low for the first cycle after reset release.
    assign rx_ready = armed_q &&
                      (state_q inside {StLenHi, StLenLo, StData, StChk});
    assign rx_fire  = rx_valid && rx_ready;

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        words_d   = words_q;
        pk_clear  = 1'b0;
        pk_load   = 1'b0;
        len_rx    = {len_hi_q, rx_byte};
        words_inc = words_q + 1'b1;
`ifdef DMEM_BOOT_CHECKSUM_EN
        chk_d = chk_q;
        if (rx_fire && (state_q != StChk)) begin
            chk_d = chk_q ^ rx_byte;
        end
`endif
        unique case (state_q)
            StLenHi: begin
                if (rx_fire) begin
                    len_hi_d = rx_byte;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                pk_clear = 1'b1;
                if (rx_fire) begin
                    len_d = len_rx;
                    if (len_rx == '0) begin
                        state_d = StFinal;
                    end else if (32'(len_rx) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                pk_load = rx_fire;
                if (pk_valid) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                words_d = words_inc;
                state_d = (32'(words_inc) == 32'(len_q)) ? StFinal : StData;
            end
`ifdef DMEM_BOOT_CHECKSUM_EN
            StChk: begin
                if (rx_fire) begin
                    state_d = (rx_byte == chk_q) ? StDone : StError;
                end
            end
`endif
            StDone, StError: begin
                state_d = state_q;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StLenHi;
            armed_q  <= 1'b0;
            len_hi_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            words_q  <= words_d;
        end
    end

`ifdef DMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chk_q <= CHK_INIT;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    // The CPU only ever sees dmem once the load has completed successfully.
    always_comb begin
        if (state_q == StDone) begin
            address_dmem = cpu_address;
            data         = cpu_data;
            wren         = cpu_wren;
        end else begin
            address_dmem = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
            data         = pk_word;
            wren         = (state_q == StWrite);
        end
    end

    assign cpu_reset    = (state_q != StDone);
    assign done         = (state_q == StDone);
    assign error        = (state_q == StError);
    assign words_loaded = words_q;

endmodule
